// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the stage registers and hazard_ctrl.
// Combinational controls and registered counters; no backpressure.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             mem_timeout;
  logic [CNT_W-1:0] cycle_cnt, ldstall_cnt, redirect_cnt, memwait_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, mem_timeout,
           cycle_cnt, ldstall_cnt, redirect_cnt, memwait_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, mem_timeout,
           cycle_cnt, ldstall_cnt, redirect_cnt, memwait_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard unit: post-reset drain, memory-wait stalls with timeout, forwarding, perf counters.
// Stall/flush/forward are same-cycle from state + inputs; memory wait stalls every stage until MemReadyM.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {DRAIN, RUN, MEMWAIT} state_t;

  state_t           state;
  logic [DW-1:0]    drain_cnt;
  logic [WW-1:0]    wait_cnt;
  logic             timeout_q;
  logic [CNT_W-1:0] cyc_q, lds_q, red_q, mw_q;

  logic active, memwait, loaduse_hit, redirect, ldstall;

  assign active      = (state != DRAIN);
  assign memwait     = active & hz.MemReqM & ~hz.MemReadyM;
  assign loaduse_hit = (hz.ResultSrcE == 2'b01) & (hz.RdE != 5'd0) &
                       ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));
  // A taken redirect squashes the dependent instruction, so it overrides load-use.
  assign redirect    = active & ~memwait & hz.PCSrcE;
  assign ldstall     = active & ~memwait & ~hz.PCSrcE & loaduse_hit;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == rs)      fwd_sel = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == rs) fwd_sel = 2'b01;
    else                                                     fwd_sel = 2'b00;
  endfunction

  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (!active) begin
      hz.StallF = 1'b1;
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushW = 1'b1;
    end else begin
      hz.ForwardAE = fwd_sel(hz.Rs1E);
      hz.ForwardBE = fwd_sel(hz.Rs2E);
      if (memwait) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushW = 1'b1;
      end else if (redirect) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (ldstall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DRAIN;
      drain_cnt <= DW'(DRAIN_CYCLES);
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      cyc_q     <= '0;
      lds_q     <= '0;
      red_q     <= '0;
      mw_q      <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt - DW'(1);
      if (drain_cnt == DW'(1)) state <= RUN;
    end else begin
      state <= memwait ? MEMWAIT : RUN;
      cyc_q <= cyc_q + CNT_W'(1);
      lds_q <= lds_q + CNT_W'(ldstall);
      red_q <= red_q + CNT_W'(redirect);
      mw_q  <= mw_q + CNT_W'(memwait);
      if (memwait) begin
        if (wait_cnt != WW'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WW'(1);
        // Flag on the edge that completes the MEM_TIMEOUT-th wait cycle.
        if (wait_cnt >= WW'(MEM_TIMEOUT - 1)) timeout_q <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign hz.mem_timeout  = timeout_q;
  assign hz.cycle_cnt    = cyc_q;
  assign hz.ldstall_cnt  = lds_q;
  assign hz.redirect_cnt = red_q;
  assign hz.memwait_cnt  = mw_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed and random stimulus, expected outputs queued per cycle and checked by a monitor.
module tb_hazard_ctrl;
  localparam int DRAIN = 4;
  localparam int MT    = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hz();

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .hz(hz)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rse;
    logic       pcs, rwm, mreq, mrdy, rww, rst;
  } stim_t;

  typedef struct {
    logic        sf, sd, se, sm, fd, fe, fw, tmo;
    logic [1:0]  fa, fb;
    logic [31:0] cyc, lds, red, mw;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: drain progress, wait-run length, counters.
  int          m_drain_left = DRAIN;
  bit          m_running = 0;
  int          m_wait_run = 0;
  bit          m_tmo = 0;
  bit [31:0]   m_cyc = 0, m_lds = 0, m_red = 0, m_mw = 0;

  function automatic logic [1:0] mfwd(input logic [4:0] rs, input stim_t s);
    if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rst  = 1'b1;
    s.mrdy = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   mwc, lu;
    @(negedge clk);
    reset          = s.rst;
    hz.Rs1D        = s.rs1d;  hz.Rs2D = s.rs2d;
    hz.Rs1E        = s.rs1e;  hz.Rs2E = s.rs2e;
    hz.RdE         = s.rde;   hz.ResultSrcE = s.rse;
    hz.PCSrcE      = s.pcs;   hz.RdM = s.rdm;
    hz.RegWriteM   = s.rwm;   hz.MemReqM = s.mreq;
    hz.MemReadyM   = s.mrdy;  hz.RdW = s.rdw;
    hz.RegWriteW   = s.rww;
    e = '{default: '0};
    if (!s.rst) begin
      m_drain_left = DRAIN; m_running = 0; m_wait_run = 0; m_tmo = 0;
      m_cyc = 0; m_lds = 0; m_red = 0; m_mw = 0;
    end
    e.tmo = m_tmo; e.cyc = m_cyc; e.lds = m_lds; e.red = m_red; e.mw = m_mw;
    if (!s.rst || !m_running) begin
      e.sf = 1; e.fd = 1; e.fe = 1; e.fw = 1;
      if (s.rst) begin
        m_drain_left--;
        if (m_drain_left == 0) m_running = 1;
      end
    end else begin
      mwc  = s.mreq && !s.mrdy;
      lu   = (s.rse == 2'b01) && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
      e.fa = mfwd(s.rs1e, s);
      e.fb = mfwd(s.rs2e, s);
      if (mwc) begin
        e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
      end else if (s.pcs) begin
        e.fd = 1; e.fe = 1;
      end else if (lu) begin
        e.sf = 1; e.sd = 1; e.fe = 1;
      end
      m_cyc++;
      if (mwc) begin
        m_mw++;
        if (m_wait_run < MT) m_wait_run++;
        if (m_wait_run >= MT) m_tmo = 1;
      end else begin
        m_wait_run = 0;
        if (s.pcs) m_red++;
        else if (lu) m_lds++;
      end
    end
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Monitor: outputs settle after the negedge drive; sample 2 time units later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("StallF", 32'(hz.StallF), 32'(e.sf));
        chk("StallD", 32'(hz.StallD), 32'(e.sd));
        chk("StallE", 32'(hz.StallE), 32'(e.se));
        chk("StallM", 32'(hz.StallM), 32'(e.sm));
        chk("FlushD", 32'(hz.FlushD), 32'(e.fd));
        chk("FlushE", 32'(hz.FlushE), 32'(e.fe));
        chk("FlushW", 32'(hz.FlushW), 32'(e.fw));
        chk("ForwardAE", 32'(hz.ForwardAE), 32'(e.fa));
        chk("ForwardBE", 32'(hz.ForwardBE), 32'(e.fb));
        chk("mem_timeout", 32'(hz.mem_timeout), 32'(e.tmo));
        chk("cycle_cnt", hz.cycle_cnt, e.cyc);
        chk("ldstall_cnt", hz.ldstall_cnt, e.lds);
        chk("redirect_cnt", hz.redirect_cnt, e.red);
        chk("memwait_cnt", hz.memwait_cnt, e.mw);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    // Reset low for 3 cycles, then drain plus a few idle RUN cycles.
    s = idle(); s.rst = 0;
    repeat (3) step(s);
    s = idle();
    repeat (DRAIN + 3) step(s);
    // Forwarding: M over W, then W only, then x0 never forwarded.
    s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5; s.rs2e = 0;
    step(s);
    s.rwm = 0;  step(s);
    s.rwm = 1; s.rdm = 0; s.rdw = 0; step(s);
    // Load-use alone, then load-use masked by redirect.
    s = idle(); s.rse = 2'b01; s.rde = 7; s.rs2d = 7;
    step(s);
    s.pcs = 1; step(s);
    // Three memory-wait cycles with a held redirect, then release.
    s = idle(); s.mreq = 1; s.mrdy = 0; s.pcs = 1;
    repeat (3) step(s);
    s.mrdy = 1; step(s);
    // Long wait to trip the timeout; flag must stay after release.
    s = idle(); s.mreq = 1; s.mrdy = 0;
    repeat (20) step(s);
    s.mrdy = 1; step(s);
    s = idle(); repeat (2) step(s);
    // Reset asserted on the 5th memory-wait cycle.
    s = idle(); s.mreq = 1; s.mrdy = 0;
    repeat (4) step(s);
    s.rst = 0; repeat (2) step(s);
    s = idle(); repeat (DRAIN + 3) step(s);
    // Random traffic with small register indices to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
      s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
      s.rde  = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
      s.rdw  = 5'($urandom_range(0, 3)); s.rse  = 2'($urandom_range(0, 3));
      s.pcs  = ($urandom_range(0, 5) == 0);
      s.rwm  = 1'($urandom); s.rww = 1'($urandom);
      s.mreq = 1'($urandom);
      s.mrdy = ($urandom_range(0, 3) != 0);
      s.rst  = ($urandom_range(0, 199) != 0);
      step(s);
    end
    @(negedge clk);
    #4;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
